// File: rtl/vram_writer.sv
// Snoops CPU writes to screen RAM (bank 5 / bank 7) and replays them into the VRAM write port via a FIFO.
// Optional: define VRAM_WRITER_DROPCNT_EN to add a saturating drop_cnt[7:0] output.
module vram_writer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk_sys,
  input  logic          nRESET,
  input  logic          flush,
  input  logic [15:0]   addr,
  input  logic [7:0]    din,
  input  logic          nMREQ,
  input  logic          nWR,
  input  logic          nRFSH,
  input  logic          m128,
  input  logic [2:0]    page_ram,
  output logic          vram_req,
  output logic [14:0]   vram_waddr,
  output logic [7:0]    vram_wdata,
  input  logic          vram_ack,
  output logic [AW:0]   fifo_level,
`ifdef VRAM_WRITER_DROPCNT_EN
  output logic [7:0]    drop_cnt,
`endif
  output logic          overflow
);

  typedef struct packed {
    logic        bank7;
    logic [13:0] ofs;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  entry_t          mem [DEPTH];
  entry_t          cap, head;
  logic [AW-1:0]   wr_ptr, rd_ptr, head_ptr;
  logic [AW:0]     level;
  logic            wr_s, wr_q;
  logic            bank5_hit, bank7_hit;
  logic            push, pop, full, push_ok, drop;
  state_t          state_q, state_d;
  logic            load_head, head_next;

  // Decode: bank 5 at 4000-7FFF always, or at C000 when paged in 128 mode; bank 7 only via C000.
  assign bank5_hit = (addr[15:14] == 2'b01) |
                     (m128 & (addr[15:14] == 2'b11) & (page_ram == 3'd5));
  assign bank7_hit = m128 & (addr[15:14] == 2'b11) & (page_ram == 3'd7);

  assign wr_s    = ~nMREQ & ~nWR & nRFSH;
  assign push    = wr_s & ~wr_q & (bank5_hit | bank7_hit) & ~flush;
  assign pop     = vram_req & vram_ack & ~flush;
  assign full    = (level == (AW+1)'(DEPTH));
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign cap.bank7 = bank7_hit;
  assign cap.ofs   = addr[13:0];
  assign cap.data  = din;

  assign fifo_level = level;
  assign vram_req   = (state_q == S_REQ);

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) wr_q <= 1'b0;
    else         wr_q <= wr_s;
  end

  // Storage is not reset; level/pointers alone define which slots are valid.
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr] <= cap;
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef VRAM_WRITER_DROPCNT_EN
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET)                        drop_cnt <= 8'd0;
    else if (flush)                     drop_cnt <= 8'd0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    head_next = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level != '0) begin
          state_d   = S_REQ;
          load_head = 1'b1;
        end
      end
      S_REQ: begin
        // On ack, either present the following entry straight away or fall back to idle.
        if (pop) begin
          if (level > (AW+1)'(1)) begin
            load_head = 1'b1;
            head_next = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d   = S_IDLE;
      load_head = 1'b0;
    end
  end

  assign head_ptr = head_next ? (rd_ptr + AW'(1)) : rd_ptr;
  assign head     = mem[head_ptr];

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      vram_waddr <= '0;
      vram_wdata <= '0;
    end else if (load_head) begin
      vram_waddr <= {head.bank7, head.ofs};
      vram_wdata <= head.data;
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: decode, latency, FIFO ordering, overflow, flush and async reset.
module tb_vram_writer;

  logic        clk_sys = 1'b0;
  logic        nRESET;
  logic        flush;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        nMREQ, nWR, nRFSH, m128;
  logic [2:0]  page_ram;
  logic        vram_req;
  logic [14:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        vram_ack;
  logic [3:0]  fifo_level;
  logic        overflow;
`ifdef VRAM_WRITER_DROPCNT_EN
  logic [7:0]  drop_cnt;
`endif

  integer total = 0;
  integer bad   = 0;

  always #5 clk_sys = ~clk_sys;

  vram_writer #(.DEPTH(8), .AW(3)) dut (
    .clk_sys(clk_sys), .nRESET(nRESET), .flush(flush), .addr(addr), .din(din),
    .nMREQ(nMREQ), .nWR(nWR), .nRFSH(nRFSH), .m128(m128), .page_ram(page_ram),
    .vram_req(vram_req), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
    .vram_ack(vram_ack), .fifo_level(fifo_level),
`ifdef VRAM_WRITER_DROPCNT_EN
    .drop_cnt(drop_cnt),
`endif
    .overflow(overflow)
  );

  // One-cycle CPU write; returns on the falling edge after the capture edge with the bus idle.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    addr = a; din = d; nMREQ = 1'b0; nWR = 1'b0;
    @(negedge clk_sys);
    nMREQ = 1'b1; nWR = 1'b1;
  endtask

  task automatic do_flush();
    @(negedge clk_sys);
    flush = 1'b1;
    @(negedge clk_sys);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    nRESET = 1'b0; flush = 1'b0; addr = 16'h0; din = 8'h0;
    nMREQ = 1'b1; nWR = 1'b1; nRFSH = 1'b1; m128 = 1'b0; page_ram = 3'd0; vram_ack = 1'b0;
    #12;
    total++; if (vram_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", vram_req); end
    total++; if (vram_waddr !== 15'h0) begin bad++; $display("FAIL reset_waddr got=%h exp=0", vram_waddr); end
    total++; if (vram_wdata !== 8'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", vram_wdata); end
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    @(negedge clk_sys);
    nRESET = 1'b1;
  endtask

  task automatic test_basic();
    vram_ack = 1'b1;
    cpu_write(16'h4000, 8'hA5);
    total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL basic_level1 got=%0d exp=1", fifo_level); end
    total++; if (vram_req !== 1'b0) begin bad++; $display("FAIL basic_req_early got=%b exp=0", vram_req); end
    @(negedge clk_sys);
    total++; if (vram_req !== 1'b1) begin bad++; $display("FAIL basic_req got=%b exp=1", vram_req); end
    total++; if (vram_waddr !== 15'h0000) begin bad++; $display("FAIL basic_waddr got=%h exp=0000", vram_waddr); end
    total++; if (vram_wdata !== 8'hA5) begin bad++; $display("FAIL basic_wdata got=%h exp=a5", vram_wdata); end
    @(negedge clk_sys);
    total++; if (vram_req !== 1'b0) begin bad++; $display("FAIL basic_req_drop got=%b exp=0", vram_req); end
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL basic_level0 got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_paging();
    vram_ack = 1'b1; m128 = 1'b1; page_ram = 3'd7;
    cpu_write(16'hDAFF, 8'h3C);
    @(negedge clk_sys);
    total++; if (vram_req !== 1'b1) begin bad++; $display("FAIL bank7_req got=%b exp=1", vram_req); end
    total++; if (vram_waddr !== 15'h5AFF) begin bad++; $display("FAIL bank7_waddr got=%h exp=5aff", vram_waddr); end
    total++; if (vram_wdata !== 8'h3C) begin bad++; $display("FAIL bank7_wdata got=%h exp=3c", vram_wdata); end
    @(negedge clk_sys);
    page_ram = 3'd5;
    cpu_write(16'hC123, 8'h77);
    @(negedge clk_sys);
    total++; if (vram_waddr !== 15'h0123 || vram_req !== 1'b1) begin
      bad++; $display("FAIL bank5_c000 got=%h req=%b exp=0123 req=1", vram_waddr, vram_req); end
    @(negedge clk_sys);
    page_ram = 3'd3;
    cpu_write(16'hDAFF, 8'h11);
    for (int i = 0; i < 4; i++) begin
      total++; if (vram_req !== 1'b0 || fifo_level !== 4'd0) begin
        bad++; $display("FAIL page3_ignored req=%b level=%0d exp req=0 level=0", vram_req, fifo_level); end
      @(negedge clk_sys);
    end
    m128 = 1'b0; page_ram = 3'd5;
    cpu_write(16'hC000, 8'h22);
    @(negedge clk_sys);
    total++; if (vram_req !== 1'b0 || fifo_level !== 4'd0) begin
      bad++; $display("FAIL c000_48k_ignored req=%b level=%0d exp 0/0", vram_req, fifo_level); end
  endtask

  task automatic test_ignore();
    vram_ack = 1'b1;
    @(negedge clk_sys);
    nRFSH = 1'b0;
    cpu_write(16'h4000, 8'h99);
    nRFSH = 1'b1;
    cpu_write(16'h8000, 8'h98);
    cpu_write(16'h0000, 8'h97);
    for (int i = 0; i < 3; i++) begin
      total++; if (vram_req !== 1'b0 || fifo_level !== 4'd0) begin
        bad++; $display("FAIL ignore req=%b level=%0d exp 0/0", vram_req, fifo_level); end
      @(negedge clk_sys);
    end
  endtask

  task automatic test_long_write();
    vram_ack = 1'b0;
    @(negedge clk_sys);
    addr = 16'h5555; din = 8'h5A; nMREQ = 1'b0; nWR = 1'b0;
    repeat (4) @(negedge clk_sys);
    nMREQ = 1'b1; nWR = 1'b1;
    @(negedge clk_sys);
    total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL long_write_level got=%0d exp=1", fifo_level); end
    total++; if (vram_req !== 1'b1 || vram_waddr !== 15'h1555 || vram_wdata !== 8'h5A) begin
      bad++; $display("FAIL long_write_head req=%b waddr=%h wdata=%h exp 1/1555/5a", vram_req, vram_waddr, vram_wdata); end
    vram_ack = 1'b1;
    @(negedge clk_sys);
    vram_ack = 1'b0;
    total++; if (vram_req !== 1'b0 || fifo_level !== 4'd0) begin
      bad++; $display("FAIL long_write_drain req=%b level=%0d exp 0/0", vram_req, fifo_level); end
  endtask

  task automatic test_overflow();
    vram_ack = 1'b0;
    for (int i = 0; i < 10; i++) cpu_write(16'h4000 + 16'(i), 8'h10 + 8'(i));
    total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
`ifdef VRAM_WRITER_DROPCNT_EN
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
`endif
    vram_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (vram_req !== 1'b1 || vram_waddr !== 15'(i) || vram_wdata !== 8'h10 + 8'(i)) begin
        bad++; $display("FAIL ovf_drain[%0d] req=%b waddr=%h wdata=%h exp 1/%h/%h",
                        i, vram_req, vram_waddr, vram_wdata, 15'(i), 8'h10 + 8'(i)); end
      @(negedge clk_sys);
    end
    vram_ack = 1'b0;
    total++; if (vram_req !== 1'b0 || fifo_level !== 4'd0) begin
      bad++; $display("FAIL ovf_empty req=%b level=%0d exp 0/0", vram_req, fifo_level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_flush();
    do_flush();
    total++; if (overflow !== 1'b0 || fifo_level !== 4'd0) begin
      bad++; $display("FAIL flush_clear ovf=%b level=%0d exp 0/0", overflow, fifo_level); end
`ifdef VRAM_WRITER_DROPCNT_EN
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL flush_drop_cnt got=%0d exp=0", drop_cnt); end
`endif
    vram_ack = 1'b0;
    cpu_write(16'h4010, 8'h01);
    cpu_write(16'h4011, 8'h02);
    // Flush coincides with a fresh capture; that capture must vanish too.
    @(negedge clk_sys);
    addr = 16'h4012; din = 8'h03; nMREQ = 1'b0; nWR = 1'b0; flush = 1'b1;
    @(negedge clk_sys);
    nMREQ = 1'b1; nWR = 1'b1; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (vram_req !== 1'b0 || fifo_level !== 4'd0) begin
        bad++; $display("FAIL flush_discard req=%b level=%0d exp 0/0", vram_req, fifo_level); end
      @(negedge clk_sys);
    end
  endtask

  task automatic test_full_push_pop();
    vram_ack = 1'b0;
    for (int i = 0; i < 8; i++) cpu_write(16'h4020 + 16'(i), 8'h20 + 8'(i));
    @(negedge clk_sys);
    addr = 16'h4100; din = 8'hEE; nMREQ = 1'b0; nWR = 1'b0; vram_ack = 1'b1;
    @(negedge clk_sys);
    nMREQ = 1'b1; nWR = 1'b1; vram_ack = 1'b0;
    total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL full_pp_level got=%0d exp=8", fifo_level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_pp_overflow got=%b exp=0", overflow); end
    vram_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [14:0] ea;
      logic [7:0]  ed;
      ea = (i < 7) ? 15'h0021 + 15'(i) : 15'h0100;
      ed = (i < 7) ? 8'h21 + 8'(i) : 8'hEE;
      total++; if (vram_req !== 1'b1 || vram_waddr !== ea || vram_wdata !== ed) begin
        bad++; $display("FAIL full_pp_order[%0d] req=%b waddr=%h wdata=%h exp 1/%h/%h",
                        i, vram_req, vram_waddr, vram_wdata, ea, ed); end
      @(negedge clk_sys);
    end
    vram_ack = 1'b0;
    total++; if (vram_req !== 1'b0 || fifo_level !== 4'd0) begin
      bad++; $display("FAIL full_pp_empty req=%b level=%0d exp 0/0", vram_req, fifo_level); end
  endtask

  task automatic test_reset_mid_req();
    vram_ack = 1'b0;
    cpu_write(16'h4030, 8'h30);
    cpu_write(16'h4031, 8'h31);
    cpu_write(16'h4032, 8'h32);
    total++; if (vram_req !== 1'b1 || fifo_level !== 4'd3) begin
      bad++; $display("FAIL rst_mid_setup req=%b level=%0d exp 1/3", vram_req, fifo_level); end
    #2 nRESET = 1'b0;
    #1;
    total++; if (vram_req !== 1'b0 || fifo_level !== 4'd0) begin
      bad++; $display("FAIL rst_mid_async req=%b level=%0d exp 0/0", vram_req, fifo_level); end
    @(negedge clk_sys);
    nRESET = 1'b1;
    vram_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      total++; if (vram_req !== 1'b0 || fifo_level !== 4'd0) begin
        bad++; $display("FAIL rst_mid_stale req=%b level=%0d exp 0/0", vram_req, fifo_level); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_paging();
    test_ignore();
    test_long_write();
    test_overflow();
    test_flush();
    test_full_push_pop();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
